// File: rtl/datapath_seq.sv
// Purpose : self-sequencing datapath - register file, A/B operand registers, shifter,
//           ALU, result register C and {V,N,Z} status; an FSM runs one whole op per
//           start/done handshake (load: 2 edges, ALU: 5 edges incl. accept edge).
// Ports   : clk/reset (async active-high); start + op_* + datapath_in describe the op
//           and are captured on the accepting edge; busy/done report progress;
//           datapath_out = C, status = {V,N,Z}; dbg_num/dbg_data = combinational reg read.
module datapath_seq #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8,
   parameter int IMM_W = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     op_load,
   input  logic [$clog2(NREGS)-1:0] op_ra,
   input  logic [$clog2(NREGS)-1:0] op_rb,
   input  logic [$clog2(NREGS)-1:0] op_rd,
   input  logic                     op_asel,
   input  logic                     op_bsel,
   input  logic [IMM_W-1:0]         op_imm,
   input  logic [1:0]               op_shift,
   input  logic [1:0]               op_aluop,
   input  logic                     op_wb,
   input  logic [WIDTH-1:0]         datapath_in,
   input  logic [$clog2(NREGS)-1:0] dbg_num,
   output logic                     busy,
   output logic                     done,
   output logic [WIDTH-1:0]         datapath_out,
   output logic [2:0]               status,
   output logic [WIDTH-1:0]         dbg_data
);

   localparam int RW = $clog2(NREGS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LD   = 3'd1;
   localparam logic [2:0] S_RA   = 3'd2;
   localparam logic [2:0] S_RB   = 3'd3;
   localparam logic [2:0] S_EX   = 3'd4;
   localparam logic [2:0] S_WB   = 3'd5;

   logic [2:0]       state;
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] c_reg;
   logic [2:0]       status_reg;
   logic             done_reg;

   // Op fields frozen at the accepting edge so input changes while busy are ignored.
   logic [RW-1:0]    q_ra;
   logic [RW-1:0]    q_rb;
   logic [RW-1:0]    q_rd;
   logic             q_asel;
   logic             q_bsel;
   logic [IMM_W-1:0] q_imm;
   logic [1:0]       q_shift;
   logic [1:0]       q_aluop;
   logic             q_wb;
   logic [WIDTH-1:0] q_din;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] imm_ext;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] result;
   logic             ovf;

   assign imm_ext = {{(WIDTH-IMM_W){q_imm[IMM_W-1]}}, q_imm};

   always_comb begin
      shifted = b_reg;
      case (q_shift)
         2'b01:   shifted = {b_reg[WIDTH-2:0], 1'b0};
         2'b10:   shifted = {1'b0, b_reg[WIDTH-1:1]};
         2'b11:   shifted = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
         default: shifted = b_reg;
      endcase
   end

   assign ain = q_asel ? '0 : a_reg;
   assign bin = q_bsel ? imm_ext : shifted;

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (q_aluop)
         2'b00: begin
            result = ain + bin;
            // same-sign operands producing a different-sign sum
            ovf = (ain[WIDTH-1] == bin[WIDTH-1]) && (result[WIDTH-1] != ain[WIDTH-1]);
         end
         2'b01: begin
            result = ain - bin;
            // opposite-sign operands where the difference loses A's sign
            ovf = (ain[WIDTH-1] != bin[WIDTH-1]) && (result[WIDTH-1] != ain[WIDTH-1]);
         end
         2'b10:   result = ain & bin;
         default: result = ~bin;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         c_reg      <= '0;
         status_reg <= '0;
         done_reg   <= 1'b0;
         q_ra       <= '0;
         q_rb       <= '0;
         q_rd       <= '0;
         q_asel     <= 1'b0;
         q_bsel     <= 1'b0;
         q_imm      <= '0;
         q_shift    <= '0;
         q_aluop    <= '0;
         q_wb       <= 1'b0;
         q_din      <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         // done marks the cycle after the completing edge, when the FSM is back in IDLE
         done_reg <= (state == S_LD) || (state == S_WB);
         case (state)
            S_IDLE: begin
               if (start) begin
                  q_ra    <= op_ra;
                  q_rb    <= op_rb;
                  q_rd    <= op_rd;
                  q_asel  <= op_asel;
                  q_bsel  <= op_bsel;
                  q_imm   <= op_imm;
                  q_shift <= op_shift;
                  q_aluop <= op_aluop;
                  q_wb    <= op_wb;
                  q_din   <= datapath_in;
                  state   <= op_load ? S_LD : S_RA;
               end
            end
            S_LD: begin
               regs[q_rd] <= q_din;
               state      <= S_IDLE;
            end
            S_RA: begin
               a_reg <= regs[q_ra];
               state <= S_RB;
            end
            S_RB: begin
               b_reg <= regs[q_rb];
               state <= S_EX;
            end
            S_EX: begin
               c_reg      <= result;
               status_reg <= {ovf, result[WIDTH-1], (result == '0)};
               state      <= S_WB;
            end
            S_WB: begin
               if (q_wb) regs[q_rd] <= c_reg;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy         = (state != S_IDLE);
   assign done         = done_reg;
   assign datapath_out = c_reg;
   assign status       = status_reg;
   assign dbg_data     = regs[dbg_num];

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a default 16-bit/8-register instance plus an
// 8-bit/4-register instance; each task drives one scenario and checks inline.
module tb_datapath_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, op_load, op_asel, op_bsel, op_wb;
   logic [2:0]  op_ra, op_rb, op_rd, dbg_num;
   logic [4:0]  op_imm;
   logic [1:0]  op_shift, op_aluop;
   logic [15:0] datapath_in, datapath_out, dbg_data;
   logic        busy, done;
   logic [2:0]  status;

   logic        s_start, s_op_load, s_op_asel, s_op_bsel, s_op_wb;
   logic [1:0]  s_op_ra, s_op_rb, s_op_rd, s_dbg_num;
   logic [4:0]  s_op_imm;
   logic [1:0]  s_op_shift, s_op_aluop;
   logic [7:0]  s_datapath_in, s_datapath_out, s_dbg_data;
   logic        s_busy, s_done;
   logic [2:0]  s_status;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   datapath_seq dut (
      .clk(clk), .reset(reset), .start(start), .op_load(op_load),
      .op_ra(op_ra), .op_rb(op_rb), .op_rd(op_rd), .op_asel(op_asel),
      .op_bsel(op_bsel), .op_imm(op_imm), .op_shift(op_shift), .op_aluop(op_aluop),
      .op_wb(op_wb), .datapath_in(datapath_in), .dbg_num(dbg_num), .busy(busy),
      .done(done), .datapath_out(datapath_out), .status(status), .dbg_data(dbg_data)
   );

   datapath_seq #(.WIDTH(8), .NREGS(4), .IMM_W(5)) dut_s (
      .clk(clk), .reset(reset), .start(s_start), .op_load(s_op_load),
      .op_ra(s_op_ra), .op_rb(s_op_rb), .op_rd(s_op_rd), .op_asel(s_op_asel),
      .op_bsel(s_op_bsel), .op_imm(s_op_imm), .op_shift(s_op_shift), .op_aluop(s_op_aluop),
      .op_wb(s_op_wb), .datapath_in(s_datapath_in), .dbg_num(s_dbg_num), .busy(s_busy),
      .done(s_done), .datapath_out(s_datapath_out), .status(s_status), .dbg_data(s_dbg_data)
   );

   task automatic set_alu(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                          input logic asel, input logic bsel, input logic [4:0] imm,
                          input logic [1:0] sh, input logic [1:0] alu, input logic wb);
      op_load = 1'b0; op_ra = ra; op_rb = rb; op_rd = rd; op_asel = asel;
      op_bsel = bsel; op_imm = imm; op_shift = sh; op_aluop = alu; op_wb = wb;
   endtask

   // Issue the op on the inputs; returns edges from accept to done (-1 on timeout).
   // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
   task automatic run_op(output int lat);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!done) lat = -1;
   endtask

   task automatic do_load(input logic [2:0] rd, input logic [15:0] val);
      int lat;
      op_load = 1'b1; op_rd = rd; datapath_in = val;
      run_op(lat);
      op_load = 1'b0;
      tests_run++;
      if (lat !== 1) begin
         tests_failed++;
         $display("FAIL load_latency R%0d: got %0d edges, expected 1", rd, lat);
      end
   endtask

   task automatic read_reg(input logic [2:0] idx, output logic [15:0] val);
      dbg_num = idx; #1; val = dbg_data;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      int bad;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy_done: got busy=%b done=%b, expected 0 0", busy, done);
      end
      tests_run++;
      if (datapath_out !== 16'h0 || status !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_c_status: got C=%h st=%b, expected 0000 000", datapath_out, status);
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         if (v !== 16'h0) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL reset_regs: %0d nonzero registers, expected 0", bad);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op;
      logic [15:0] v;
      int bad, pulses;
      do_load(3'd2, 16'h1234);
      read_reg(3'd2, v);
      tests_run++;
      if (v !== 16'h1234) begin
         tests_failed++;
         $display("FAIL midrst_preload: got R2=%h, expected 1234", v);
      end
      set_alu(3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1);
      start = 1'b1;
      @(posedge clk); #1;            // accepted -> RA
      start = 1'b0;
      @(posedge clk); #1;            // RB
      @(posedge clk); #1;            // EX
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_busy_before: got busy=%b, expected 1", busy);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if (busy !== 1'b0 || datapath_out !== 16'h0 || status !== 3'b000) begin
         tests_failed++;
         $display("FAIL midrst_state: got busy=%b C=%h st=%b, expected 0 0000 000",
                  busy, datapath_out, status);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         read_reg(3'(i), v);
         if (v !== 16'h0) bad++;
      end
      tests_run++;
      if (pulses != 0 || bad != 0) begin
         tests_failed++;
         $display("FAIL midrst_after: got %0d done pulses, %0d nonzero regs, expected 0 0",
                  pulses, bad);
      end
   endtask

   task automatic test_add;
      logic [15:0] v;
      int lat;
      do_load(3'd1, 16'h0007);
      do_load(3'd2, 16'h0009);
      set_alu(3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1);
      run_op(lat);
      tests_run++;
      if (lat !== 4) begin
         tests_failed++;
         $display("FAIL add_latency: got %0d edges after accept, expected 4", lat);
      end
      read_reg(3'd3, v);
      tests_run++;
      if (datapath_out !== 16'h0010 || status !== 3'b000 || v !== 16'h0010) begin
         tests_failed++;
         $display("FAIL add_result: got C=%h st=%b R3=%h, expected 0010 000 0010",
                  datapath_out, status, v);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_done_width: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_overflow;
      logic [15:0] v;
      int lat;
      do_load(3'd1, 16'h7FFF);
      set_alu(3'd1, 3'd0, 3'd4, 1'b0, 1'b1, 5'b00001, 2'b00, 2'b00, 1'b1);
      run_op(lat);
      read_reg(3'd4, v);
      tests_run++;
      if (datapath_out !== 16'h8000 || status !== 3'b110 || v !== 16'h8000) begin
         tests_failed++;
         $display("FAIL add_ovf: got C=%h st=%b R4=%h, expected 8000 110 8000",
                  datapath_out, status, v);
      end
      set_alu(3'd4, 3'd4, 3'd4, 1'b0, 1'b0, 5'd0, 2'b00, 2'b01, 1'b0);
      run_op(lat);
      read_reg(3'd4, v);
      tests_run++;
      if (datapath_out !== 16'h0000 || status !== 3'b001 || v !== 16'h8000) begin
         tests_failed++;
         $display("FAIL cmp_zero: got C=%h st=%b R4=%h, expected 0000 001 8000",
                  datapath_out, status, v);
      end
   endtask

   task automatic test_shift_not;
      int lat;
      do_load(3'd5, 16'h8001);
      set_alu(3'd0, 3'd5, 3'd6, 1'b0, 1'b0, 5'd0, 2'b11, 2'b11, 1'b1);
      run_op(lat);
      tests_run++;
      if (datapath_out !== 16'h3FFF || status !== 3'b000) begin
         tests_failed++;
         $display("FAIL not_asr: got C=%h st=%b, expected 3fff 000", datapath_out, status);
      end
      set_alu(3'd0, 3'd5, 3'd6, 1'b0, 1'b0, 5'd0, 2'b01, 2'b11, 1'b1);
      run_op(lat);
      tests_run++;
      if (datapath_out !== 16'hFFFD || status !== 3'b010) begin
         tests_failed++;
         $display("FAIL not_shl: got C=%h st=%b, expected fffd 010", datapath_out, status);
      end
      // A bypassed (asel) so the sum is just the logical right shift of 0x8001
      set_alu(3'd5, 3'd5, 3'd6, 1'b1, 1'b0, 5'd0, 2'b10, 2'b00, 1'b1);
      run_op(lat);
      tests_run++;
      if (datapath_out !== 16'h4000 || status !== 3'b000) begin
         tests_failed++;
         $display("FAIL asel_lsr: got C=%h st=%b, expected 4000 000", datapath_out, status);
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] v5, v6, first_c;
      int pulses, overlap;
      do_load(3'd1, 16'h0007);
      do_load(3'd2, 16'h0009);
      set_alu(3'd1, 3'd2, 3'd5, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1);
      start = 1'b1;
      @(posedge clk); #1;            // ADD accepted
      // These fields must not disturb the ADD; they form the next op, taken in the done cycle
      set_alu(3'd2, 3'd1, 3'd6, 1'b0, 1'b0, 5'd0, 2'b00, 2'b01, 1'b1);
      pulses = 0; overlap = 0; first_c = 16'hxxxx;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); #1;
         if (done && busy) overlap++;
         if (done) begin
            pulses++;
            if (pulses == 1) first_c = datapath_out;
         end
      end
      start = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (pulses != 2 || overlap != 0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_handshake: got pulses=%0d overlap=%0d busy=%b, expected 2 0 0",
                  pulses, overlap, busy);
      end
      read_reg(3'd5, v5);
      read_reg(3'd6, v6);
      tests_run++;
      if (first_c !== 16'h0010 || v5 !== 16'h0010 || v6 !== 16'h0002 || datapath_out !== 16'h0002) begin
         tests_failed++;
         $display("FAIL b2b_results: got C1=%h R5=%h R6=%h C=%h, expected 0010 0010 0002 0002",
                  first_c, v5, v6, datapath_out);
      end
   endtask

   task automatic s_run(output int lat);
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      lat = 0;
      while (!s_done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!s_done) lat = -1;
   endtask

   task automatic test_small;
      int lat;
      logic [7:0] vals [3];
      logic [7:0] v3;
      vals[0] = 8'hFF; vals[1] = 8'h01; vals[2] = 8'h55;
      for (int i = 0; i < 3; i++) begin
         s_op_load = 1'b1;
         s_op_rd = (i == 2) ? 2'd3 : 2'(i);
         s_datapath_in = vals[i];
         s_run(lat);
      end
      s_dbg_num = 2'd3; #1;
      tests_run++;
      if (s_dbg_data !== 8'h55) begin
         tests_failed++;
         $display("FAIL small_load_top: got R3=%h, expected 55", s_dbg_data);
      end
      s_op_load = 1'b0; s_op_ra = 2'd0; s_op_rb = 2'd1; s_op_rd = 2'd3;
      s_op_asel = 1'b0; s_op_bsel = 1'b0; s_op_imm = 5'd0; s_op_shift = 2'b00;
      s_op_aluop = 2'b00; s_op_wb = 1'b1;
      s_run(lat);
      v3 = s_dbg_data;
      tests_run++;
      if (lat !== 4 || s_datapath_out !== 8'h00 || s_status !== 3'b001 || v3 !== 8'h00) begin
         tests_failed++;
         $display("FAIL small_add_wrap: got lat=%0d C=%h st=%b R3=%h, expected 4 00 001 00",
                  lat, s_datapath_out, s_status, v3);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; datapath_in = '0; dbg_num = '0;
      set_alu(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0);
      s_start = 1'b0; s_op_load = 1'b0; s_op_ra = '0; s_op_rb = '0; s_op_rd = '0;
      s_op_asel = 1'b0; s_op_bsel = 1'b0; s_op_imm = '0; s_op_shift = '0;
      s_op_aluop = '0; s_op_wb = 1'b0; s_datapath_in = '0; s_dbg_num = '0;
      test_reset;
      test_reset_mid_op;
      test_add;
      test_overflow;
      test_shift_not;
      test_back_to_back;
      test_small;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
